// File: rtl/des_expand_xor.sv
// des_expand_xor: DES expansion E(R) XOR K written into a small output FIFO
module des_expand_xor #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [31:0]      r_data_in,
    input  logic [47:0]      key_in,
    input  logic             r_data_in_valid,
    output logic             r_data_in_ready,
    output logic [47:0]      s_data_out,
    output logic             s_data_out_valid,
    input  logic             s_data_out_ready,
    output logic [CNT_W-1:0] fifo_count
);
    localparam int PW = $clog2(DEPTH);

    logic [33:0]      r_ext;
    logic [47:0]      e_r;
    logic [47:0]      word;
    logic             push;
    logic             pop;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] after_pop;
    logic [47:0]      head_q, head_d;
    logic [47:0]      mem_q [DEPTH];
    logic [47:0]      mem_d [DEPTH];

    // R with DES bit 32 placed ahead of bit 1 and bit 1 after bit 32, so every E group is a plain slice
    assign r_ext = {r_data_in[0], r_data_in, r_data_in[31]};

    for (genvar g = 0; g < 8; g++) begin : g_exp
        assign e_r[47-6*g -: 6] = r_ext[33-4*g -: 6];
    end

    assign r_data_in_ready  = cnt_q != CNT_W'(DEPTH);
    assign s_data_out_valid = cnt_q != '0;
    assign s_data_out       = head_q;
    assign fifo_count       = cnt_q;

    // FIFO bookkeeping; head register preloads the entry that will be at the head after this edge
    always_comb begin
        word      = e_r ^ key_in;
        push      = r_data_in_valid && r_data_in_ready;
        pop       = s_data_out_valid && s_data_out_ready;
        cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
        after_pop = cnt_q - CNT_W'(pop);
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        mem_d     = mem_q;
        if (push) mem_d[wr_ptr_q] = word;
        head_d    = cnt_d == '0 ? head_q : (after_pop == '0 ? word : mem_q[rd_ptr_d]);
    end

    // state registers, cleared by synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_des_expand_xor.sv
// tb_des_expand_xor: directed vectors plus a queue model checked every cycle
module tb_des_expand_xor;
    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic [31:0]      r_data_in = '0;
    logic [47:0]      key_in = '0;
    logic             r_data_in_valid = 1'b0;
    logic             r_data_in_ready;
    logic [47:0]      s_data_out;
    logic             s_data_out_valid;
    logic             s_data_out_ready = 1'b1;
    logic [CNT_W-1:0] fifo_count;

    int n_chk = 0;
    int n_pass = 0;
    bit live = 1'b0;
    logic [47:0] q [$];

    int e_tab [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                       16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    des_expand_xor #(.DEPTH(DEPTH)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .r_data_in(r_data_in),
        .key_in(key_in),
        .r_data_in_valid(r_data_in_valid),
        .r_data_in_ready(r_data_in_ready),
        .s_data_out(s_data_out),
        .s_data_out_valid(s_data_out_valid),
        .s_data_out_ready(s_data_out_ready),
        .fifo_count(fifo_count)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [47:0] e_xor(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-e_tab[i]];
        return e ^ k;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic send(input logic [31:0] rv, input logic [47:0] kv);
        int t = 0;
        @(posedge clk_in);
        #1;
        r_data_in_valid = 1'b1;
        r_data_in = rv;
        key_in = kv;
        @(negedge clk_in);
        while (!r_data_in_ready && t < 20) begin
            @(negedge clk_in);
            t++;
        end
        chk("accept_timeout", 64'(t < 20), 64'd1);
        @(posedge clk_in);
        #1 r_data_in_valid = 1'b0;
    endtask

    // model advances on each edge from the driven inputs, then DUT outputs are compared mid-cycle
    initial begin
        bit pop, push;
        forever begin
            @(posedge clk_in);
            if (rst_in) begin
                q.delete();
                live = 1'b1;
            end else if (live) begin
                pop = q.size() > 0 && s_data_out_ready;
                push = r_data_in_valid && q.size() < DEPTH;
                if (pop) void'(q.pop_front());
                if (push) q.push_back(e_xor(r_data_in, key_in));
            end
            @(negedge clk_in);
            if (live && !rst_in) begin
                chk("m_valid", 64'(s_data_out_valid), 64'(q.size() > 0));
                chk("m_count", 64'(fifo_count), 64'(q.size()));
                chk("m_ready", 64'(r_data_in_ready), 64'(q.size() < DEPTH));
                if (q.size() > 0) chk("m_data", 64'(s_data_out), 64'(q[0]));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        chk("rst_valid", 64'(s_data_out_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ready", 64'(r_data_in_ready), 64'd1);
        chk("rst_data", 64'(s_data_out), 64'd0);

        send(32'h00000000, 48'h1B02EFFC7072);
        @(negedge clk_in);
        chk("zero_r_valid", 64'(s_data_out_valid), 64'd1);
        chk("zero_r_data", 64'(s_data_out), 64'h1B02EFFC7072);
        chk("model_zero_r", 64'(e_xor(32'h0, 48'h1B02EFFC7072)), 64'h1B02EFFC7072);

        send(32'hF0AAF0AA, 48'h1B02EFFC7072);
        @(negedge clk_in);
        chk("f0aa_data", 64'(s_data_out), 64'h6117BA866527);
        chk("model_e_f0aa", 64'(e_xor(32'hF0AAF0AA, 48'h0)), 64'h7A15557A1555);

        send(32'h80000000, 48'h0);
        @(negedge clk_in);
        chk("wrap_msb", 64'(s_data_out), 64'h400000000001);
        send(32'h00000001, 48'h0);
        @(negedge clk_in);
        chk("wrap_lsb", 64'(s_data_out), 64'h800000000002);
        send(32'hFFFFFFFF, 48'hFFFFFFFFFFFF);
        @(negedge clk_in);
        chk("all_ones", 64'(s_data_out), 64'h000000000000);

        @(posedge clk_in);
        #1;
        s_data_out_ready = 1'b0;
        r_data_in_valid = 1'b1;
        r_data_in = 32'h80000000;
        key_in = 48'h0;
        @(posedge clk_in);
        #1 r_data_in = 32'h00000001;
        @(posedge clk_in);
        #1;
        r_data_in = 32'hFFFFFFFF;
        key_in = 48'hFFFFFFFFFFFF;
        @(posedge clk_in);
        #1 r_data_in_valid = 1'b0;
        @(negedge clk_in);
        chk("bp_count", 64'(fifo_count), 64'd2);
        chk("bp_ready", 64'(r_data_in_ready), 64'd0);
        chk("bp_head", 64'(s_data_out), 64'h400000000001);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("bp_head_stable", 64'(s_data_out), 64'h400000000001);
        @(posedge clk_in);
        #1 s_data_out_ready = 1'b1;
        @(negedge clk_in);
        chk("bp_ready_not_same_cycle", 64'(r_data_in_ready), 64'd0);
        @(negedge clk_in);
        chk("bp_ready_after_pop", 64'(r_data_in_ready), 64'd1);
        chk("bp_second", 64'(s_data_out), 64'h800000000002);
        @(negedge clk_in);
        chk("bp_drained", 64'(s_data_out_valid), 64'd0);

        @(posedge clk_in);
        #1 r_data_in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            r_data_in = $urandom;
            key_in = {16'($urandom), $urandom};
            @(negedge clk_in);
            if (i > 0) chk("stream_count", 64'(fifo_count), 64'd1);
            @(posedge clk_in);
            #1;
        end
        r_data_in_valid = 1'b0;
        repeat (3) @(posedge clk_in);

        #1;
        s_data_out_ready = 1'b0;
        r_data_in_valid = 1'b1;
        r_data_in = 32'h12345678;
        key_in = 48'hABCDEF012345;
        repeat (2) @(posedge clk_in);
        #1 r_data_in_valid = 1'b0;
        @(negedge clk_in);
        chk("pre_rst_count", 64'(fifo_count), 64'd2);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        r_data_in_valid = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        r_data_in_valid = 1'b0;
        @(negedge clk_in);
        chk("mid_rst_valid", 64'(s_data_out_valid), 64'd0);
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_ready", 64'(r_data_in_ready), 64'd1);
        chk("mid_rst_data", 64'(s_data_out), 64'd0);
        s_data_out_ready = 1'b1;
        send(32'h00000000, 48'h1B02EFFC7072);
        @(negedge clk_in);
        chk("post_rst_data", 64'(s_data_out), 64'h1B02EFFC7072);
        @(negedge clk_in);
        chk("post_rst_empty", 64'(s_data_out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
